ritc_phase_scan_sequencer: RTL and testbench
============================================

Name: ritc_phase_scan_sequencer

Overview:
- Hardware sequencer for the RITC dual phase scanner, replacing firmware bit-banging of PSEN/PSINCDEC.
- Steps the scan MMCM phase N times in a chosen direction. Per step: waits for PSDONE, strobes the scan registers, waits out the mux/store pipeline, then samples the selected scan bit.
- Accumulates the ones count, first rising-transition index and net phase position; results are read back through the scanner register file.

Parameters:
STEP_W, 12, width of step count and result counters (max 4095 steps)
TIMEOUT, 255, user_clk_i cycles allowed between PSEN and PSDONE before error
CAPTURE_DELAY, 3, cycles from scan_o pulse to valid sample_i

Ports:
user_clk_i  in  1  system/user clock
user_rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle start request
abort_i  in  1  one-cycle abort request
dir_i  in  1  1 = increment phase, 0 = decrement; latched at start
nsteps_i  in  STEP_W  number of phase steps; latched at start
clear_pos_i  in  1  zero position_o; honoured only in IDLE
sample_i  in  1  selected scan bit (clock/signal/VCDL mux output)
psdone_i  in  1  MMCM PSDONE
psen_o  out  1  MMCM PSEN, one-cycle pulse
psincdec_o  out  1  MMCM PSINCDEC
scan_o  out  1  capture strobe to scanner registers (do_scan)
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle completion pulse
aborted_o  out  1  sticky; run ended by abort
timeout_o  out  1  sticky; PSDONE timeout occurred
ones_count_o  out  STEP_W  number of samples equal to 1
edge_found_o  out  1  a 0->1 transition was seen
edge_pos_o  out  STEP_W  sample index (1-based) of first 0->1 transition
position_o  out  16  net signed phase position, two's complement

Behaviour:
- Reset: all outputs 0; state IDLE; all internal counters 0.
- States: IDLE, PULSE, WAIT_DONE, SCAN, SETTLE, SAMPLE, ABORT_WAIT.
- IDLE:
  - start_i latches dir_i and nsteps_i.
  - Clears ones_count_o, edge_found_o, edge_pos_o, aborted_o, timeout_o and the step index.
  - nsteps_i = 0: done_o pulses next cycle, state stays IDLE, no PSEN issued.
  - Otherwise go to PULSE.
  - start_i outside IDLE is ignored.
  - clear_pos_i in IDLE zeroes position_o next cycle. If clear_pos_i and start_i arrive together, both act.
- PULSE: psen_o = 1 for exactly one cycle, psincdec_o = latched dir, timeout counter cleared; go to WAIT_DONE.
  - psincdec_o holds its value until the next PULSE.
- WAIT_DONE:
  - psdone_i = 1: position_o += 1 (dir = 1) or -= 1 (dir = 0), wrapping modulo 2^16; go to SCAN.
  - Timeout counter reaches TIMEOUT: set timeout_o, pulse done_o, go to IDLE. position_o is unchanged.
  - abort_i (no psdone_i): go to ABORT_WAIT.
  - psdone_i and abort_i in the same cycle: position is updated, then go to IDLE with aborted_o set and done_o pulsed.
- ABORT_WAIT:
  - Waits for psdone_i or timeout; PSEN is never reissued until PSDONE is seen.
  - On psdone_i: update position, set aborted_o, pulse done_o, go to IDLE.
  - On timeout: set both timeout_o and aborted_o, pulse done_o, go to IDLE.
- SCAN: scan_o = 1 for one cycle; increment step index; go to SETTLE.
- SETTLE: count CAPTURE_DELAY-1 cycles, so sample_i is registered exactly CAPTURE_DELAY cycles after the scan_o cycle.
- SAMPLE:
  - If sample = 1, ones_count_o += 1.
  - First sample of a run only initialises the previous-sample register.
  - Later samples: on prev = 0 and cur = 1 with edge_found_o = 0, set edge_found_o and edge_pos_o = step index.
  - If step index == nsteps, pulse done_o and go to IDLE; else go to PULSE next cycle.
- abort_i in PULSE, SCAN, SETTLE or SAMPLE: finish the current step (including sample accounting), then end as in the final-step case with aborted_o set.
- Counters never overflow: ones_count ≤ nsteps ≤ 2^STEP_W - 1.
- Result outputs are stable from done_o until the next accepted start_i.
- Async reset mid-run returns to IDLE immediately. The MMCM may still be finishing a step; software must allow 1 µs before the next start.

Test Plan:
- Start dir=1, nsteps=4, psdone_i returned 5 cycles after each psen_o, sample_i = 0,0,1,1 → 4 psen_o pulses with psincdec_o=1, 4 scan_o pulses, ones_count=2, edge_found=1, edge_pos=3, position=4, done_o once, busy_o low after.
- Start nsteps=0 → done_o the following cycle, psen_o never asserted, position unchanged.
- psdone_i withheld, TIMEOUT=255 → timeout_o=1 and done_o 256±1 cycles after psen_o, position unchanged, busy_o=0.
- abort_i during WAIT_DONE of step 2 of 10, psdone_i 20 cycles later → no further psen_o, aborted_o=1, position=2, done_o pulsed after psdone_i.
- position=0, dir=0, nsteps=3 → position_o=0xFFFD. Then clear_pos_i in IDLE → 0x0000.
- sample_i forced 1 on all 6 steps → ones_count=6, edge_found=0, edge_pos=0; start_i pulsed mid-run is ignored (single done_o).

Source files
------------

// File: rtl/ritc_phase_scan_sequencer.sv
// rtl/ritc_phase_scan_sequencer.sv - RITC phase scan sequencer: steps the scan MMCM phase and samples the scan bit once per step.
// Accumulates the ones count, the first rising-edge index and the net signed phase position.
module ritc_phase_scan_sequencer #(
  parameter int STEP_W        = 12,
  parameter int TIMEOUT       = 255,
  parameter int CAPTURE_DELAY = 3
) (
  input  logic              user_clk_i,
  input  logic              user_rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              dir_i,
  input  logic [STEP_W-1:0] nsteps_i,
  input  logic              clear_pos_i,
  input  logic              sample_i,
  input  logic              psdone_i,
  output logic              psen_o,
  output logic              psincdec_o,
  output logic              scan_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic              timeout_o,
  output logic [STEP_W-1:0] ones_count_o,
  output logic              edge_found_o,
  output logic [STEP_W-1:0] edge_pos_o,
  output logic [15:0]       position_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int SET_W = (CAPTURE_DELAY > 2) ? $clog2(CAPTURE_DELAY) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(CAPTURE_DELAY - 2);
  localparam logic [TMO_W-1:0]  TMO_ONE  = 1;
  localparam logic [SET_W-1:0]  SET_ONE  = 1;
  localparam logic [STEP_W-1:0] STEP_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_WAIT_DONE, S_SCAN, S_SETTLE, S_SAMPLE, S_ABORT_WAIT
  } state_t;

  state_t            state_q;
  logic              dir_q, prev_q, abort_pend_q;
  logic [STEP_W-1:0] nsteps_q, step_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [SET_W-1:0]  set_q;
  logic              psen_q, psincdec_q, scan_q, done_q, aborted_q, timeout_q;
  logic [STEP_W-1:0] ones_q, edge_pos_q;
  logic              edge_found_q;
  logic [15:0]       pos_q;
  logic [15:0]       pos_step;

  assign pos_step = dir_q ? (pos_q + 16'd1) : (pos_q - 16'd1);

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state_q      <= S_IDLE;
      dir_q        <= 1'b0;
      prev_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      nsteps_q     <= '0;
      step_q       <= '0;
      tmo_q        <= '0;
      set_q        <= '0;
      psen_q       <= 1'b0;
      psincdec_q   <= 1'b0;
      scan_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      timeout_q    <= 1'b0;
      ones_q       <= '0;
      edge_found_q <= 1'b0;
      edge_pos_q   <= '0;
      pos_q        <= '0;
    end else begin
      psen_q <= 1'b0;
      scan_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_pos_i) pos_q <= '0;
          if (start_i) begin
            dir_q        <= dir_i;
            nsteps_q     <= nsteps_i;
            ones_q       <= '0;
            edge_found_q <= 1'b0;
            edge_pos_q   <= '0;
            aborted_q    <= 1'b0;
            timeout_q    <= 1'b0;
            step_q       <= '0;
            abort_pend_q <= 1'b0;
            if (nsteps_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q    <= S_PULSE;
              psen_q     <= 1'b1;
              psincdec_q <= dir_i;
            end
          end
        end
        S_PULSE: begin
          tmo_q <= '0;
          if (abort_i) abort_pend_q <= 1'b1;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (psdone_i) begin
            pos_q <= pos_step;
            if (abort_i) begin
              aborted_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              scan_q  <= 1'b1;
              state_q <= S_SCAN;
            end
          end else if (tmo_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            aborted_q <= abort_pend_q | abort_i;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
            if (abort_i) state_q <= S_ABORT_WAIT;
          end
        end
        // PSEN must never be reissued while the MMCM still owes a PSDONE.
        S_ABORT_WAIT: begin
          if (psdone_i) begin
            pos_q     <= pos_step;
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        S_SCAN: begin
          step_q <= step_q + STEP_ONE;
          set_q  <= '0;
          if (abort_i) abort_pend_q <= 1'b1;
          state_q <= (CAPTURE_DELAY <= 1) ? S_SAMPLE : S_SETTLE;
        end
        S_SETTLE: begin
          if (abort_i) abort_pend_q <= 1'b1;
          if (set_q == SET_LAST) state_q <= S_SAMPLE;
          else                   set_q   <= set_q + SET_ONE;
        end
        S_SAMPLE: begin
          if (sample_i) ones_q <= ones_q + STEP_ONE;
          if (step_q != STEP_ONE && !prev_q && sample_i && !edge_found_q) begin
            edge_found_q <= 1'b1;
            edge_pos_q   <= step_q;
          end
          prev_q <= sample_i;
          if (step_q == nsteps_q || abort_pend_q || abort_i) begin
            aborted_q <= abort_pend_q | abort_i;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            psen_q     <= 1'b1;
            psincdec_q <= dir_q;
            state_q    <= S_PULSE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign psen_o       = psen_q;
  assign psincdec_o   = psincdec_q;
  assign scan_o       = scan_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign timeout_o    = timeout_q;
  assign ones_count_o = ones_q;
  assign edge_found_o = edge_found_q;
  assign edge_pos_o   = edge_pos_q;
  assign position_o   = pos_q;

endmodule

// File: tb/tb_ritc_phase_scan_sequencer.sv
// tb/tb_ritc_phase_scan_sequencer.sv - bench for ritc_phase_scan_sequencer with an MMCM responder and result scoreboard.
module tb_ritc_phase_scan_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0, dir_i = 1'b0, clear_pos_i = 1'b0;
  logic        sample_i = 1'b0, psdone_i = 1'b0;
  logic [11:0] nsteps_i = '0;
  logic        psen_o, psincdec_o, scan_o, busy_o, done_o, aborted_o, timeout_o, edge_found_o;
  logic [11:0] ones_count_o, edge_pos_o;
  logic [15:0] position_o;

  ritc_phase_scan_sequencer #(.STEP_W(12), .TIMEOUT(255), .CAPTURE_DELAY(3)) dut (
    .user_clk_i(clk), .user_rst_n_i(rst_n), .start_i(start_i), .abort_i(abort_i),
    .dir_i(dir_i), .nsteps_i(nsteps_i), .clear_pos_i(clear_pos_i), .sample_i(sample_i),
    .psdone_i(psdone_i), .psen_o(psen_o), .psincdec_o(psincdec_o), .scan_o(scan_o),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .timeout_o(timeout_o),
    .ones_count_o(ones_count_o), .edge_found_o(edge_found_o), .edge_pos_o(edge_pos_o),
    .position_o(position_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ones; int ef; int ep; int pos; int ab; int to;
  } res_t;
  res_t exp_q[$];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int psen_cnt = 0, scan_cnt = 0, done_cnt = 0, psen_cyc = 0, done_cyc = 0;
  int model_cnt = 0, run_base = 0, long_step = -1, m_idx = 0;
  int samp_tab[16];
  int samp_idx = 0;
  bit withhold = 1'b0;
  logic exp_dir = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ones, input int ef, input int ep, input int pos, input int ab, input int to);
    res_t r;
    r.ones = ones; r.ef = ef; r.ep = ep; r.pos = pos; r.ab = ab; r.to = to;
    exp_q.push_back(r);
  endtask

  always @(posedge clk) cyc++;

  // PSEN monitor: counts pulses and checks the direction bit on every one.
  always @(negedge clk) begin
    if (psen_o) begin
      psen_cnt++;
      psen_cyc = cyc;
      chk("psincdec", {31'b0, psincdec_o}, {31'b0, exp_dir});
    end
    if (scan_o) begin
      scan_cnt++;
      sample_i = (samp_tab[samp_idx] != 0);
      if (samp_idx < 15) samp_idx++;
    end
  end

  // MMCM responder: PSDONE 5 cycles after PSEN, or 23 on the selected step.
  initial forever begin
    @(negedge clk);
    if (psen_o) begin
      m_idx = model_cnt - run_base;
      model_cnt++;
      if (!withhold) begin
        repeat ((m_idx == long_step) ? 23 : 5) @(negedge clk);
        psdone_i = 1'b1;
        @(negedge clk);
        psdone_i = 1'b0;
      end
    end
  end

  // Result scoreboard, popped on each done_o.
  always @(negedge clk) begin
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 expected no completion");
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("ones_count", {20'b0, ones_count_o}, e.ones);
        chk("edge_found", {31'b0, edge_found_o}, e.ef);
        chk("edge_pos",   {20'b0, edge_pos_o},   e.ep);
        chk("position",   {16'b0, position_o},   e.pos);
        chk("aborted",    {31'b0, aborted_o},    e.ab);
        chk("timeout",    {31'b0, timeout_o},    e.to);
      end
    end
  end

  task automatic set_samples(input int v0, input int v1, input int v2, input int v3, input int rest);
    for (int i = 0; i < 16; i++) samp_tab[i] = rest;
    samp_tab[0] = v0; samp_tab[1] = v1; samp_tab[2] = v2; samp_tab[3] = v3;
  endtask

  task automatic start_run(input logic d, input int n, input logic clr);
    @(posedge clk); #1;
    run_base = model_cnt;
    samp_idx = 0;
    exp_dir = d;
    dir_i = d; nsteps_i = n[11:0]; clear_pos_i = clr; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; clear_pos_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int base);
    for (int i = 0; i < budget && done_cnt == base; i++) @(posedge clk);
    n_checks++;
    if (done_cnt == base) begin
      n_fail++;
      $display("FAIL done_wait: got no done_o within %0d cycles expected done_o", budget);
    end
  endtask

  task automatic wait_psen(input int k, input int budget);
    for (int i = 0; i < budget && (model_cnt - run_base) < k; i++) @(posedge clk);
    n_checks++;
    if ((model_cnt - run_base) < k) begin
      n_fail++;
      $display("FAIL psen_wait: got %0d psen expected %0d", model_cnt - run_base, k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, d0, lat;
    for (int i = 0; i < 16; i++) samp_tab[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_psen", {31'b0, psen_o}, 0);
    chk("rst_done", {31'b0, done_o}, 0);
    chk("rst_position", {16'b0, position_o}, 0);
    chk("rst_ones", {20'b0, ones_count_o}, 0);
    rst_n = 1'b1;

    // Basic run: samples 0,0,1,1 upward.
    set_samples(0, 0, 1, 1, 0);
    p0 = psen_cnt; s0 = scan_cnt; d0 = done_cnt;
    push_exp(2, 1, 3, 4, 0, 0);
    start_run(1'b1, 4, 1'b0);
    wait_done(400, d0);
    repeat (5) @(posedge clk); #1;
    chk("t1_psen_count", psen_cnt - p0, 4);
    chk("t1_scan_count", scan_cnt - s0, 4);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_busy_after", {31'b0, busy_o}, 0);

    // Zero steps: immediate done, no PSEN.
    p0 = psen_cnt; d0 = done_cnt;
    push_exp(0, 0, 0, 4, 0, 0);
    start_run(1'b1, 0, 1'b0);
    chk("t2_done_next_cycle", {31'b0, done_o}, 1);
    wait_done(10, d0);
    repeat (3) @(posedge clk); #1;
    chk("t2_psen_count", psen_cnt - p0, 0);
    chk("t2_busy", {31'b0, busy_o}, 0);

    // PSDONE withheld: timeout.
    withhold = 1'b1;
    p0 = psen_cnt; d0 = done_cnt;
    push_exp(0, 0, 0, 4, 0, 1);
    start_run(1'b1, 1, 1'b0);
    wait_done(400, d0);
    lat = done_cyc - psen_cyc;
    chk("t3_timeout_latency_in_255_257", (lat >= 255 && lat <= 257) ? 1 : 0, 1);
    repeat (3) @(posedge clk); #1;
    chk("t3_busy", {31'b0, busy_o}, 0);
    chk("t3_psen_count", psen_cnt - p0, 1);
    withhold = 1'b0;

    // Abort during WAIT_DONE of step 2 of 10, with clear_pos at start.
    set_samples(0, 0, 0, 0, 0);
    long_step = 1;
    p0 = psen_cnt; d0 = done_cnt;
    push_exp(0, 0, 0, 2, 1, 0);
    start_run(1'b1, 10, 1'b1);
    wait_psen(2, 200);
    repeat (3) @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    wait_done(200, d0);
    repeat (10) @(posedge clk); #1;
    chk("t4_psen_count", psen_cnt - p0, 2);
    chk("t4_aborted", {31'b0, aborted_o}, 1);
    chk("t4_position", {16'b0, position_o}, 2);
    long_step = -1;

    // Downward from zero wraps, then clear_pos in IDLE.
    d0 = done_cnt;
    push_exp(0, 0, 0, 16'hFFFD, 0, 0);
    start_run(1'b0, 3, 1'b1);
    wait_done(400, d0);
    repeat (2) @(posedge clk); #1;
    chk("t5_position_wrap", {16'b0, position_o}, 32'h0000_FFFD);
    clear_pos_i = 1'b1;
    @(posedge clk); #1;
    clear_pos_i = 1'b0;
    chk("t5_position_cleared", {16'b0, position_o}, 0);

    // All-ones samples, start_i mid-run ignored.
    set_samples(1, 1, 1, 1, 1);
    p0 = psen_cnt; d0 = done_cnt;
    push_exp(6, 0, 0, 6, 0, 0);
    start_run(1'b1, 6, 1'b0);
    wait_psen(3, 200);
    dir_i = 1'b0; nsteps_i = 12'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(400, d0);
    repeat (20) @(posedge clk); #1;
    chk("t6_done_count", done_cnt - d0, 1);
    chk("t6_psen_count", psen_cnt - p0, 6);
    chk("t6_busy", {31'b0, busy_o}, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
